// File: rtl/uart_echo_tester.sv
// UART echo tester: sends an incrementing byte pattern through uart_tx and
// compares each echo returned through uart_rx. Mismatches and missing echoes
// are counted, and the run ends with a pass/fail verdict.
module uart_echo_tester #(
    parameter int unsigned NUM_BYTES      = 256,
    parameter logic [7:0]  SEED           = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tx_busy,
    output logic        tx_enable,
    output logic [7:0]  tx_data,
    input  logic        recv_valid,
    input  logic [7:0]  recv_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] IDX_LAST = 16'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ECHO,
        S_NEXT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [15:0]   idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_enable_q, tx_enable_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [15:0]   err_q, err_d;
    logic [15:0]   to_q, to_d;

    // State and output registers; reset clears everything, aborting any run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_q      <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            to_q        <= to_d;
        end
    end

    // Next-state logic: send a byte, await its echo or a timeout, advance.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        to_d        = to_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    byte_d  = SEED;
                    idx_d   = '0;
                    err_d   = '0;
                    to_d    = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_enable_d = 1'b1;
                    tx_data_d   = byte_q;
                    timer_d     = '0;
                    state_d     = S_WAIT_ECHO;
                end
            end
            S_WAIT_ECHO: begin
                timer_d = timer_q + 1'b1;
                // An echo on the final timeout cycle still counts as received.
                if (recv_valid) begin
                    if (recv_data != byte_q && err_q != '1) begin
                        err_d = err_q + 16'd1;
                    end
                    state_d = S_NEXT;
                end else if (timer_q == T_LAST) begin
                    if (to_q != '1) begin
                        to_d = to_q + 16'd1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && (to_q == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    byte_d  = byte_q + 8'd1;
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_enable     = tx_enable_q;
    assign tx_data       = tx_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign timeout_count = to_q;

endmodule
